// File: rtl/sync_pulse_rx_multi.sv
// Multi-channel toggle-handshake receiver: synchronises each sender toggle, queues edges in a
// saturating counter and returns a toggle ack. Optional sticky overflow flags: SYNC_PULSE_RX_OVF_EN.
module sync_pulse_rx_multi #(
  parameter int   CHANNELS    = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 3,
  parameter logic INIT        = 1'b0,
  parameter int   ACK_MODE    = 0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS-1:0]       sTOG,
  output logic [CHANNELS-1:0]       dACK,
  output logic [CHANNELS-1:0]       dVALID,
  input  logic [CHANNELS-1:0]       dDEQ,
  output logic [CHANNELS*CNT_W-1:0] dCOUNT
`ifdef SYNC_PULSE_RX_OVF_EN
  ,
  output logic [CHANNELS-1:0]       dOVF,
  input  logic [CHANNELS-1:0]       dOVF_CLR
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_pulse_rx_multi: SYNC_STAGES must be 2..4");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("sync_pulse_rx_multi: CHANNELS must be 1..32");
  end

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic                   ev, deq_ok, drop;

    assign ev     = sync_q[SYNC_STAGES-1] ^ last_q;
    // Dequeue qualified by the registered count, so an empty channel never underflows.
    assign deq_ok = dDEQ[gi] & (cnt_q != '0);
    assign drop   = ev & ~deq_ok & (cnt_q == CNT_MAX);

    always_comb begin
      cnt_d = cnt_q;
      if (ev && !deq_ok && cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!ev && deq_ok) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (ACK_MODE == 0) begin : g_ack_capture
      assign ack_d = sync_q[SYNC_STAGES-1];
    end else begin : g_ack_dequeue
      assign ack_d = ack_q ^ deq_ok;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync_q <= {SYNC_STAGES{INIT}};
        last_q <= INIT;
        cnt_q  <= '0;
        ack_q  <= INIT;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sTOG[gi]};
        last_q <= sync_q[SYNC_STAGES-1];
        cnt_q  <= cnt_d;
        ack_q  <= ack_d;
      end
    end

    assign dACK[gi]                  = ack_q;
    assign dVALID[gi]                = (cnt_q != '0);
    assign dCOUNT[gi*CNT_W +: CNT_W] = cnt_q;

`ifdef SYNC_PULSE_RX_OVF_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear keeps the flag set.
    assign ovf_d = drop | (ovf_q & ~dOVF_CLR[gi]);

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        ovf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_d;
      end
    end

    assign dOVF[gi] = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
  end

endmodule

// File: tb/tb_sync_pulse_rx_multi.sv
// Directed bench for sync_pulse_rx_multi: three instances (defaults, ACK_MODE=1, SYNC_STAGES=3)
// sharing one clock and reset; overflow checks enabled with SYNC_PULSE_RX_OVF_EN.
module tb_sync_pulse_rx_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [3:0]  stog_a = '0, deq_a = '0, ack_a, valid_a;
  logic [3:0]  stog_b = '0, deq_b = '0, ack_b, valid_b;
  logic [3:0]  stog_c = '0, deq_c = '0, ack_c, valid_c;
  logic [11:0] count_a, count_b, count_c;
`ifdef SYNC_PULSE_RX_OVF_EN
  logic [3:0]  ovf_a, ovf_b, ovf_c;
  logic [3:0]  ovf_clr_a = '0, ovf_clr_b = '0, ovf_clr_c = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_pulse_rx_multi #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(3), .INIT(1'b0), .ACK_MODE(0)) u_dut_a (
    .CLK(clk), .RST_N(rst_n), .sTOG(stog_a), .dACK(ack_a), .dVALID(valid_a),
    .dDEQ(deq_a), .dCOUNT(count_a)
`ifdef SYNC_PULSE_RX_OVF_EN
    , .dOVF(ovf_a), .dOVF_CLR(ovf_clr_a)
`endif
  );

  sync_pulse_rx_multi #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(3), .INIT(1'b0), .ACK_MODE(1)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .sTOG(stog_b), .dACK(ack_b), .dVALID(valid_b),
    .dDEQ(deq_b), .dCOUNT(count_b)
`ifdef SYNC_PULSE_RX_OVF_EN
    , .dOVF(ovf_b), .dOVF_CLR(ovf_clr_b)
`endif
  );

  sync_pulse_rx_multi #(.CHANNELS(4), .SYNC_STAGES(3), .CNT_W(3), .INIT(1'b0), .ACK_MODE(0)) u_dut_c (
    .CLK(clk), .RST_N(rst_n), .sTOG(stog_c), .dACK(ack_c), .dVALID(valid_c),
    .dDEQ(deq_c), .dCOUNT(count_c)
`ifdef SYNC_PULSE_RX_OVF_EN
    , .dOVF(ovf_c), .dOVF_CLR(ovf_clr_c)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Async reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_ack_a",   {28'd0, ack_a},   32'd0);
    check_eq("rst_valid_a", {28'd0, valid_a}, 32'd0);
    check_eq("rst_count_a", {20'd0, count_a}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Single pulse latency on channel 0, SYNC_STAGES=2.
    stog_a[0] = 1'b1;
    step();
    check_eq("lat_cnt_edgeN",   {20'd0, count_a}, 32'd0);
    step();
    check_eq("lat_cnt_edgeN1",  {20'd0, count_a}, 32'd0);
    check_eq("lat_ack_edgeN1",  {31'd0, ack_a[0]}, 32'd0);
    step();
    check_eq("lat_cnt_edgeN2",  {20'd0, count_a}, 32'd1);
    check_eq("lat_valid_edgeN2", {28'd0, valid_a}, 32'd1);
    check_eq("lat_ack_edgeN2",  {31'd0, ack_a[0]}, 32'd1);
    deq_a[0] = 1'b1;
    step();
    deq_a[0] = 1'b0;
    check_eq("deq_cnt",   {20'd0, count_a}, 32'd0);
    check_eq("deq_valid", {28'd0, valid_a}, 32'd0);
    check_eq("deq_ack_hold", {31'd0, ack_a[0]}, 32'd1);

    // Saturation: 9 events on channel 2, no dequeue.
    for (int i = 0; i < 9; i++) begin
      stog_a[2] = ~stog_a[2];
      step();
    end
    repeat (3) step();
    check_eq("sat_cnt2",   {29'd0, count_a[8:6]}, 32'd7);
    check_eq("sat_valid2", {31'd0, valid_a[2]},   32'd1);
`ifdef SYNC_PULSE_RX_OVF_EN
    check_eq("sat_ovf2", {31'd0, ovf_a[2]}, 32'd1);
    ovf_clr_a[2] = 1'b1;
    step();
    ovf_clr_a[2] = 1'b0;
    check_eq("ovf_clr2", {31'd0, ovf_a[2]}, 32'd0);
`endif

    // Event and dequeue on the same edge at count 7.
    stog_a[2] = ~stog_a[2];
    step();
    step();
    deq_a[2] = 1'b1;
    step();
    deq_a[2] = 1'b0;
    check_eq("evdeq_at7_cnt", {29'd0, count_a[8:6]}, 32'd7);
`ifdef SYNC_PULSE_RX_OVF_EN
    check_eq("evdeq_at7_ovf", {31'd0, ovf_a[2]}, 32'd0);
`endif
    deq_a[2] = 1'b1;
    repeat (6) step();
    deq_a[2] = 1'b0;
    check_eq("drain_to1_cnt", {29'd0, count_a[8:6]}, 32'd1);

    // Event and dequeue on the same edge at count 1.
    stog_a[2] = ~stog_a[2];
    step();
    step();
    deq_a[2] = 1'b1;
    step();
    deq_a[2] = 1'b0;
    check_eq("evdeq_at1_cnt",   {29'd0, count_a[8:6]}, 32'd1);
    check_eq("evdeq_at1_valid", {31'd0, valid_a[2]},   32'd1);
    deq_a[2] = 1'b1;
    step();
    deq_a[2] = 1'b0;
    check_eq("final_deq_cnt2", {29'd0, count_a[8:6]}, 32'd0);

    // ACK_MODE=1: ack follows consumption on channel 1.
    stog_b[1] = 1'b1;
    repeat (4) step();
    check_eq("am1_cnt_pending", {29'd0, count_b[5:3]}, 32'd1);
    check_eq("am1_ack_before",  {31'd0, ack_b[1]},     32'd0);
    deq_b[1] = 1'b1;
    step();
    deq_b[1] = 1'b0;
    check_eq("am1_ack_on_deq", {31'd0, ack_b[1]},     32'd1);
    check_eq("am1_cnt_after",  {29'd0, count_b[5:3]}, 32'd0);
    deq_b[1] = 1'b1;
    step();
    deq_b[1] = 1'b0;
    check_eq("am1_ack_empty_deq", {31'd0, ack_b[1]},     32'd1);
    check_eq("am1_cnt_empty_deq", {29'd0, count_b[5:3]}, 32'd0);

    // Independence with SYNC_STAGES=3: all channels toggle together.
    stog_c = 4'hF;
    step();
    step();
    step();
    check_eq("ss3_cnt_edgeN2", {20'd0, count_c}, 32'd0);
    step();
    check_eq("ss3_cnt_edgeN3", {20'd0, count_c}, 32'h249);
    deq_c = 4'b1000;
    step();
    deq_c = 4'b0000;
    check_eq("ss3_cnt_deq3", {20'd0, count_c}, 32'h049);
    check_eq("ss3_ack",      {28'd0, ack_c},   32'hF);

    // Reset mid-cycle with toggles in flight.
    stog_c = 4'h0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_cnt_c",   {20'd0, count_c}, 32'd0);
    check_eq("midrst_valid_c", {28'd0, valid_c}, 32'd0);
    check_eq("midrst_ack_c",   {28'd0, ack_c},   32'd0);
    check_eq("midrst_ack_a",   {28'd0, ack_a},   32'd0);
    check_eq("midrst_ack_b",   {28'd0, ack_b},   32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    check_eq("postrst_cnt_c",   {20'd0, count_c}, 32'd0);
    check_eq("postrst_valid_c", {28'd0, valid_c}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
